inst_fetch: RTL

//  Instruction fetch stage of the 9-bit CPU, directly downstream of the program counter.

---
 rtl/inst_fetch.sv | 138 +++++++++++++
 1 files changed

// File: rtl/inst_fetch.sv
// Instruction fetch stage: 256x9 instruction store with serial program load,
// LOAD -> RUN -> HALTED sequencing and a registered instruction/opcode output.
module inst_fetch #(
  parameter int unsigned    IW        = 9,
  parameter int unsigned    AW        = 8,
  parameter int unsigned    DEPTH     = 256,
  parameter logic [IW-1:0]  HALT_WORD = 9'h1FF,
  parameter logic [IW-1:0]  NOP_WORD  = 9'h000
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [AW-1:0] PC,
  input  logic          load_valid,
  input  logic [IW-1:0] load_data,
  input  logic          load_last,
  input  logic          start_load,
  input  logic          restart,
  output logic          load_ready,
  output logic          cpu_rst,
  output logic [IW-1:0] instr,
  output logic [2:0]    op,
  output logic          instr_valid,
  output logic          done,
  output logic          load_err,
  output logic [15:0]   cycle_cnt
);

  localparam int unsigned CW = 16;
  localparam logic [CW-1:0] CNT_MAX  = 16'hFFFF;
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  localparam logic [1:0] ST_LOAD = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_HALT = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [AW-1:0] load_addr_q, load_addr_d;
  logic [IW-1:0] instr_q, instr_d;
  logic          instr_valid_q, instr_valid_d;
  logic          load_err_q, load_err_d;
  logic [CW-1:0] cycle_cnt_q, cycle_cnt_d;
  logic          mem_we;
  logic [IW-1:0] rd_word;

  logic [IW-1:0] mem_q [DEPTH];

  // Asynchronous read; the full-width PC always addresses a valid word.
  assign rd_word = mem_q[PC];

  // Next-state and datapath control.
  always_comb begin
    state_d       = state_q;
    load_addr_d   = load_addr_q;
    instr_d       = NOP_WORD;
    instr_valid_d = 1'b0;
    load_err_d    = load_err_q;
    cycle_cnt_d   = cycle_cnt_q;
    mem_we        = 1'b0;

    case (state_q)
      ST_LOAD: begin
        if (load_valid) begin
          mem_we      = 1'b1;
          load_addr_d = AW'(load_addr_q + 1'b1);
          if (load_addr_q == LAST_ADDR) begin
            load_err_d = 1'b1;
          end
          if (load_last) begin
            state_d     = ST_RUN;
            cycle_cnt_d = '0;
          end
        end
      end

      ST_RUN: begin
        instr_d       = rd_word;
        instr_valid_d = 1'b1;
        if (cycle_cnt_q != CNT_MAX) begin
          cycle_cnt_d = CW'(cycle_cnt_q + 1'b1);
        end
        if (rd_word == HALT_WORD) begin
          state_d = ST_HALT;
        end
      end

      ST_HALT: begin
        if (start_load) begin
          state_d     = ST_LOAD;
          load_addr_d = '0;
          load_err_d  = 1'b0;
        end else if (restart) begin
          state_d     = ST_RUN;
          cycle_cnt_d = '0;
        end
      end

      default: begin
        state_d = ST_LOAD;
      end
    endcase
  end

  // Control and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_LOAD;
      load_addr_q   <= '0;
      instr_q       <= NOP_WORD;
      instr_valid_q <= 1'b0;
      load_err_q    <= 1'b0;
      cycle_cnt_q   <= '0;
    end else begin
      state_q       <= state_d;
      load_addr_q   <= load_addr_d;
      instr_q       <= instr_d;
      instr_valid_q <= instr_valid_d;
      load_err_q    <= load_err_d;
      cycle_cnt_q   <= cycle_cnt_d;
    end
  end

  // Instruction store survives reset so a partial load is retained.
  always_ff @(posedge clk) begin
    if (mem_we && !reset) begin
      mem_q[load_addr_q] <= load_data;
    end
  end

  assign load_ready  = (state_q == ST_LOAD);
  assign cpu_rst     = (state_q != ST_RUN);
  assign done        = (state_q == ST_HALT);
  assign instr       = instr_q;
  assign op          = instr_q[8:6];
  assign instr_valid = instr_valid_q;
  assign load_err    = load_err_q;
  assign cycle_cnt   = cycle_cnt_q;

endmodule
